// File: rtl/ball_phys_pkg.sv
// Shared constants, FSM state type and fixed-point helpers for the tilt ball physics engine.
package ball_phys_pkg;

  localparam int unsigned SCREEN_W     = 320;
  localparam int unsigned SCREEN_H     = 180;
  localparam int unsigned SPRITE_SIZE  = 32;
  localparam int unsigned COORD_W      = 10;
  localparam int unsigned FRAC_W       = 8;
  localparam int unsigned VEL_W        = 16;
  localparam int unsigned ACCEL_W      = 8;
  localparam int unsigned DEF_TICK_DIV = 35293;
  localparam int unsigned V_MAX        = 2047;
  localparam int unsigned BOUNCE_SHIFT = 1;
  localparam int unsigned INIT_X       = 100;
  localparam int unsigned INIT_Y       = 50;

  // Unsigned committed position and signed intermediate sum (2 guard bits).
  localparam int unsigned POS_W = COORD_W + FRAC_W;
  localparam int unsigned PN_W  = COORD_W + FRAC_W + 2;

  // Upper wall limits in fraction units.
  localparam int unsigned HI_X = (SCREEN_W - SPRITE_SIZE) << FRAC_W;
  localparam int unsigned HI_Y = (SCREEN_H - SPRITE_SIZE) << FRAC_W;

  localparam int unsigned HIT_LEFT   = 0;
  localparam int unsigned HIT_RIGHT  = 1;
  localparam int unsigned HIT_TOP    = 2;
  localparam int unsigned HIT_BOTTOM = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    VEL    = 2'd1,
    POS    = 2'd2,
    COMMIT = 2'd3
  } phys_state_e;

  // Limit a one-bit-wider velocity sum to +/-vmax.
  function automatic logic signed [VEL_W-1:0] saturate(
    input logic signed [VEL_W:0] v,
    input logic signed [VEL_W:0] vmax
  );
    if (v > vmax) begin
      return VEL_W'(vmax);
    end else if (v < -vmax) begin
      return VEL_W'(-vmax);
    end
    return VEL_W'(v);
  endfunction

  // Clamp a signed position into [0, hi].
  function automatic logic [POS_W-1:0] clamp_pos(
    input logic signed [PN_W-1:0] p,
    input logic        [POS_W-1:0] hi
  );
    if (p < 0) begin
      return '0;
    end else if (p > $signed({2'b00, hi})) begin
      return hi;
    end
    return POS_W'(p);
  endfunction

endpackage

// File: rtl/ball_axis.sv
// One physics axis: velocity integrate/saturate, position add, wall clamp, hit and rebound.
// Rebound vs. stick-to-wall is selected by BALL_BOUNCE_EN.
module ball_axis
  import ball_phys_pkg::*;
#(
  parameter int unsigned HI   = 0,
  parameter int unsigned INIT = 0
) (
  input  logic                      CLK,
  input  logic                      rst,
  input  logic                      i_vel_en,
  input  logic                      i_pos_en,
  input  logic                      i_commit_en,
  input  logic                      i_load,
  input  logic [COORD_W-1:0]        i_init,
  input  logic signed [ACCEL_W-1:0] i_accel,
  output logic [COORD_W-1:0]        o_pix,
  output logic                      o_hit_lo,
  output logic                      o_hit_hi
);

  localparam logic [POS_W-1:0] HI_P   = POS_W'(HI);
  localparam logic [POS_W-1:0] INIT_P = POS_W'(INIT << FRAC_W);

  logic [POS_W-1:0]        p_q, p_d, pn_q, pn_d;
  logic signed [VEL_W-1:0] v_q, v_d, v_hit;
  logic                    hlo_q, hlo_d, hhi_q, hhi_d;
  logic signed [VEL_W:0]   v_sum;
  logic signed [PN_W-1:0]  p_sum, p_load;

  // Per-phase datapath; load overrides whatever phase is in flight.
  always_comb begin
    p_d   = p_q;
    v_d   = v_q;
    pn_d  = pn_q;
    hlo_d = hlo_q;
    hhi_d = hhi_q;
    v_sum  = $signed({v_q[VEL_W-1], v_q})
           + $signed({{(VEL_W + 1 - ACCEL_W){i_accel[ACCEL_W-1]}}, i_accel});
    p_sum  = $signed({2'b00, p_q}) + $signed({{(PN_W - VEL_W){v_q[VEL_W-1]}}, v_q});
    p_load = $signed({2'b00, i_init, {FRAC_W{1'b0}}});
`ifdef BALL_BOUNCE_EN
    v_hit = -(v_q >>> BOUNCE_SHIFT);
`else
    v_hit = '0;
`endif
    if (i_vel_en) begin
      v_d = saturate(v_sum, (VEL_W + 1)'(V_MAX));
    end
    if (i_pos_en) begin
      pn_d  = clamp_pos(p_sum, HI_P);
      hlo_d = (p_sum < 0);
      hhi_d = (p_sum > $signed({2'b00, HI_P}));
      if (hlo_d || hhi_d) begin
        v_d = v_hit;
      end
    end
    if (i_commit_en) begin
      p_d = pn_q;
    end
    if (i_load) begin
      p_d   = clamp_pos(p_load, HI_P);
      v_d   = '0;
      hlo_d = 1'b0;
      hhi_d = 1'b0;
    end
  end

  // Axis state registers.
  always_ff @(posedge CLK) begin
    if (rst) begin
      p_q   <= INIT_P;
      v_q   <= '0;
      pn_q  <= INIT_P;
      hlo_q <= 1'b0;
      hhi_q <= 1'b0;
    end else begin
      p_q   <= p_d;
      v_q   <= v_d;
      pn_q  <= pn_d;
      hlo_q <= hlo_d;
      hhi_q <= hhi_d;
    end
  end

  assign o_pix    = p_q[FRAC_W +: COORD_W];
  assign o_hit_lo = hlo_q;
  assign o_hit_hi = hhi_q;

endmodule

// File: rtl/tilt_ball_physics.sv
// Tilt-game ball kinematics: tick counter, IDLE/VEL/POS/COMMIT sequencer and load path
// around two ball_axis instances. Define BALL_BOUNCE_EN for lossy wall rebound.
module tilt_ball_physics
  import ball_phys_pkg::*;
#(
  parameter int unsigned TICK_DIV = DEF_TICK_DIV
) (
  input  logic               CLK,
  input  logic               rst,
  input  logic               i_play,
  input  logic               i_load,
  input  logic [COORD_W-1:0] i_init_x,
  input  logic [COORD_W-1:0] i_init_y,
  input  logic [ACCEL_W-1:0] i_accel_x,
  input  logic [ACCEL_W-1:0] i_accel_y,
  output logic [COORD_W-1:0] o_bl_x,
  output logic [COORD_W-1:0] o_bl_y,
  output logic [3:0]         o_hit,
  output logic               o_update
);

  localparam int unsigned CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  phys_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       o_hit_q, o_hit_d;
  logic             o_update_q, o_update_d;
  logic             tick;
  logic             x_lo, x_hi, y_lo, y_hi;

  // Tick generation, phase sequencing and output pulses; load restarts everything.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    o_hit_d    = '0;
    o_update_d = 1'b0;
    tick       = i_play && (cnt_q == CNT_W'(TICK_DIV - 1));
    if (i_play) begin
      cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
    end
    unique case (state_q)
      IDLE:    if (tick) state_d = VEL;
      VEL:     state_d = POS;
      POS:     state_d = COMMIT;
      COMMIT: begin
        o_update_d          = 1'b1;
        o_hit_d[HIT_LEFT]   = x_lo;
        o_hit_d[HIT_RIGHT]  = x_hi;
        o_hit_d[HIT_TOP]    = y_lo;
        o_hit_d[HIT_BOTTOM] = y_hi;
        state_d             = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (i_load) begin
      state_d    = IDLE;
      cnt_d      = '0;
      o_update_d = 1'b1;
      o_hit_d    = '0;
    end
  end

  // Sequencer and output registers.
  always_ff @(posedge CLK) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      o_hit_q    <= '0;
      o_update_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      o_hit_q    <= o_hit_d;
      o_update_q <= o_update_d;
    end
  end

  ball_axis #(.HI(HI_X), .INIT(INIT_X)) u_axis_x (
    .CLK         (CLK),
    .rst         (rst),
    .i_vel_en    (state_q == VEL),
    .i_pos_en    (state_q == POS),
    .i_commit_en (state_q == COMMIT),
    .i_load      (i_load),
    .i_init      (i_init_x),
    .i_accel     (i_accel_x),
    .o_pix       (o_bl_x),
    .o_hit_lo    (x_lo),
    .o_hit_hi    (x_hi)
  );

  ball_axis #(.HI(HI_Y), .INIT(INIT_Y)) u_axis_y (
    .CLK         (CLK),
    .rst         (rst),
    .i_vel_en    (state_q == VEL),
    .i_pos_en    (state_q == POS),
    .i_commit_en (state_q == COMMIT),
    .i_load      (i_load),
    .i_init      (i_init_y),
    .i_accel     (i_accel_y),
    .o_pix       (o_bl_y),
    .o_hit_lo    (y_lo),
    .o_hit_hi    (y_hi)
  );

  assign o_hit    = o_hit_q;
  assign o_update = o_update_q;

endmodule

// File: tb/tb_tilt_ball_physics.sv
// Scoreboard bench for tilt_ball_physics with a fast physics tick.
module tb_tilt_ball_physics;

  localparam int TD   = 4;
  localparam int HIX  = (320 - 32) * 256;
  localparam int HIY  = (180 - 32) * 256;
  localparam int VMAX = 2047;

  logic       CLK = 1'b0;
  logic       rst;
  logic       i_play;
  logic       i_load;
  logic [9:0] i_init_x, i_init_y;
  logic [7:0] i_accel_x, i_accel_y;
  logic [9:0] o_bl_x, o_bl_y;
  logic [3:0] o_hit;
  logic       o_update;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic [3:0] hit;
  } exp_t;

  exp_t       exp_q[$];
  int         n_cmp = 0;
  int         n_bad = 0;
  logic [3:0] last_hit = 4'b0;
  int         mx, my, mvx, mvy;

  tilt_ball_physics #(.TICK_DIV(TD)) dut (
    .CLK       (CLK),
    .rst       (rst),
    .i_play    (i_play),
    .i_load    (i_load),
    .i_init_x  (i_init_x),
    .i_init_y  (i_init_y),
    .i_accel_x (i_accel_x),
    .i_accel_y (i_accel_y),
    .o_bl_x    (o_bl_x),
    .o_bl_y    (o_bl_y),
    .o_hit     (o_hit),
    .o_update  (o_update)
  );

  always #5 CLK = ~CLK;

  // Reference model of one axis for one tick.
  task automatic model_axis(inout int p, inout int v, input int a, input int hi,
                            output logic lo_h, output logic hi_h);
    int pn;
    v = v + a;
    if (v > VMAX) v = VMAX;
    if (v < -VMAX) v = -VMAX;
    pn   = p + v;
    lo_h = 1'b0;
    hi_h = 1'b0;
    if (pn < 0) begin
      p = 0; lo_h = 1'b1;
    end else if (pn > hi) begin
      p = hi; hi_h = 1'b1;
    end else begin
      p = pn;
    end
    if (lo_h || hi_h) begin
`ifdef BALL_BOUNCE_EN
      v = -(v >>> 1);
`else
      v = 0;
`endif
    end
  endtask

  task automatic model_tick(input int ax, input int ay);
    logic xl, xh, yl, yh;
    exp_t e;
    model_axis(mx, mvx, ax, HIX, xl, xh);
    model_axis(my, mvy, ay, HIY, yl, yh);
    e.x   = 10'(mx / 256);
    e.y   = 10'(my / 256);
    e.hit = {yh, yl, xh, xl};
    exp_q.push_back(e);
  endtask

  task automatic do_load(input int x, input int y);
    exp_t e;
    @(negedge CLK);
    i_init_x = 10'(x);
    i_init_y = 10'(y);
    i_load   = 1'b1;
    mx  = (x * 256 > HIX) ? HIX : x * 256;
    my  = (y * 256 > HIY) ? HIY : y * 256;
    mvx = 0;
    mvy = 0;
    e.x = 10'(mx / 256);
    e.y = 10'(my / 256);
    e.hit = 4'b0;
    exp_q.push_back(e);
    @(negedge CLK);
    i_load = 1'b0;
  endtask

  // Exactly n ticks of play time from a zero counter, then wait for outputs to drain.
  task automatic run_ticks(input int n, input int ax, input int ay);
    i_accel_x = 8'(ax);
    i_accel_y = 8'(ay);
    for (int k = 0; k < n; k++) model_tick(ax, ay);
    i_play = 1'b1;
    repeat (n * TD) @(negedge CLK);
    i_play = 1'b0;
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) @(negedge CLK);
    repeat (2) @(negedge CLK);
  endtask

  // Pops one expectation per o_update pulse.
  task automatic scoreboard();
    exp_t e;
    forever begin
      @(negedge CLK);
      if (!rst && o_update) begin
        n_cmp++;
        last_hit = o_hit;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL sb_unexpected_update: got x=%0d y=%0d hit=%b, required no update",
                   o_bl_x, o_bl_y, o_hit);
        end else begin
          e = exp_q.pop_front();
          if ({o_bl_x, o_bl_y, o_hit} !== e) begin
            n_bad++;
            $display("FAIL sb_update: got x=%0d y=%0d hit=%b, required x=%0d y=%0d hit=%b",
                     o_bl_x, o_bl_y, o_hit, e.x, e.y, e.hit);
          end
        end
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; i_play = 1'b0; i_load = 1'b1;
    i_init_x = 10'd5; i_init_y = 10'd5;
    i_accel_x = 8'd0; i_accel_y = 8'd0;
    repeat (3) @(negedge CLK);
    n_cmp++; if (o_bl_x !== 10'd100) begin n_bad++; $display("FAIL reset_x: got %0d required 100", o_bl_x); end
    n_cmp++; if (o_bl_y !== 10'd50) begin n_bad++; $display("FAIL reset_y: got %0d required 50", o_bl_y); end
    n_cmp++; if (o_hit !== 4'b0) begin n_bad++; $display("FAIL reset_hit: got %b required 0000", o_hit); end
    n_cmp++; if (o_update !== 1'b0) begin n_bad++; $display("FAIL reset_update: got %b required 0", o_update); end
    rst = 1'b0; i_load = 1'b0;
    mx = 100 * 256; my = 50 * 256; mvx = 0; mvy = 0;
    repeat (2) @(negedge CLK);
  endtask

  task automatic test_integrate();
    run_ticks(16, 16, 0);
    n_cmp++; if (exp_q.size() != 0) begin n_bad++; $display("FAIL integ_drain: got %0d pending required 0", exp_q.size()); end
    n_cmp++; if (o_bl_x !== 10'd108) begin n_bad++; $display("FAIL integ_x: got %0d required 108", o_bl_x); end
    n_cmp++; if (o_bl_y !== 10'd50) begin n_bad++; $display("FAIL integ_y: got %0d required 50", o_bl_y); end
  endtask

  task automatic test_saturation();
    do_load(0, 0);
    run_ticks(20, 127, 0);
    n_cmp++; if (o_bl_x !== 10'd99) begin n_bad++; $display("FAIL sat_pos_x: got %0d required 99", o_bl_x); end
    do_load(287, 0);
    run_ticks(20, -128, 0);
    n_cmp++; if (o_bl_x !== 10'd187) begin n_bad++; $display("FAIL sat_neg_x: got %0d required 187", o_bl_x); end
    n_cmp++; if (exp_q.size() != 0) begin n_bad++; $display("FAIL sat_drain: got %0d pending required 0", exp_q.size()); end
  endtask

  task automatic test_right_wall();
    logic [9:0] x_after;
`ifdef BALL_BOUNCE_EN
    x_after = 10'd287;
`else
    x_after = 10'd288;
`endif
    do_load(287, 0);
    run_ticks(1, 127, 0);
    n_cmp++; if (o_bl_x !== 10'd287) begin n_bad++; $display("FAIL wall_pre_x: got %0d required 287", o_bl_x); end
    run_ticks(1, 127, 0);
    n_cmp++; if (o_bl_x !== 10'd288) begin n_bad++; $display("FAIL wall_x: got %0d required 288", o_bl_x); end
    n_cmp++; if (last_hit !== 4'b0010) begin n_bad++; $display("FAIL wall_hit: got %b required 0010", last_hit); end
    run_ticks(1, 0, 0);
    n_cmp++; if (o_bl_x !== x_after) begin n_bad++; $display("FAIL wall_after_x: got %0d required %0d", o_bl_x, x_after); end
    n_cmp++; if (last_hit !== 4'b0000) begin n_bad++; $display("FAIL wall_after_hit: got %b required 0000", last_hit); end
  endtask

  task automatic test_corner();
    do_load(0, 0);
    run_ticks(1, -128, -128);
    n_cmp++; if ({o_bl_x, o_bl_y} !== 20'd0) begin n_bad++; $display("FAIL corner_pos: got (%0d,%0d) required (0,0)", o_bl_x, o_bl_y); end
    n_cmp++; if (last_hit !== 4'b0101) begin n_bad++; $display("FAIL corner_hit: got %b required 0101", last_hit); end
  endtask

  task automatic test_load_clamp_bottom();
    do_load(1023, 200);
    n_cmp++; if ({o_bl_x, o_bl_y} !== {10'd288, 10'd148}) begin n_bad++; $display("FAIL load_clamp: got (%0d,%0d) required (288,148)", o_bl_x, o_bl_y); end
    run_ticks(1, 0, 100);
    n_cmp++; if (last_hit !== 4'b1000) begin n_bad++; $display("FAIL bottom_hit: got %b required 1000", last_hit); end
    n_cmp++; if (o_bl_y !== 10'd148) begin n_bad++; $display("FAIL bottom_y: got %0d required 148", o_bl_y); end
  endtask

  task automatic test_load_during_pos();
    exp_t e;
    do_load(50, 50);
    i_accel_x = 8'd64; i_accel_y = 8'd64;
    i_play = 1'b1;
    repeat (TD) @(negedge CLK);
    i_play = 1'b0;
    @(negedge CLK);
    i_load = 1'b1; i_init_x = 10'd10; i_init_y = 10'd20;
    mx = 10 * 256; my = 20 * 256; mvx = 0; mvy = 0;
    e.x = 10'd10; e.y = 10'd20; e.hit = 4'b0;
    exp_q.push_back(e);
    @(negedge CLK);
    i_load = 1'b0;
    n_cmp++; if ({o_update, o_bl_x, o_bl_y, o_hit} !== {1'b1, 10'd10, 10'd20, 4'b0})
      begin n_bad++; $display("FAIL load_pos: got upd=%b (%0d,%0d) hit=%b required upd=1 (10,20) hit=0000", o_update, o_bl_x, o_bl_y, o_hit); end
    repeat (10) @(negedge CLK);
    n_cmp++; if (exp_q.size() != 0) begin n_bad++; $display("FAIL load_pos_drain: got %0d pending required 0", exp_q.size()); end
    run_ticks(1, 0, 0);
    n_cmp++; if ({o_bl_x, o_bl_y} !== {10'd10, 10'd20}) begin n_bad++; $display("FAIL load_vel_zero: got (%0d,%0d) required (10,20)", o_bl_x, o_bl_y); end
  endtask

  task automatic test_play_toggle();
    i_accel_x = 8'd16; i_accel_y = 8'd0;
    @(negedge CLK);
    i_play = 1'b1;
    repeat (2) @(negedge CLK);
    i_play = 1'b0;
    repeat (100) @(negedge CLK);
    n_cmp++; if (o_update !== 1'b0) begin n_bad++; $display("FAIL toggle_hold: got update=%b required 0", o_update); end
    model_tick(16, 0);
    i_play = 1'b1;
    repeat (2) @(negedge CLK);
    i_play = 1'b0;
    repeat (2) @(negedge CLK);
    n_cmp++; if (o_update !== 1'b0) begin n_bad++; $display("FAIL toggle_early: got update=%b required 0", o_update); end
    @(negedge CLK);
    n_cmp++; if (o_update !== 1'b1) begin n_bad++; $display("FAIL toggle_tick: got update=%b required 1", o_update); end
    repeat (3) @(negedge CLK);
    n_cmp++; if (exp_q.size() != 0) begin n_bad++; $display("FAIL toggle_drain: got %0d pending required 0", exp_q.size()); end
  endtask

  task automatic test_back_to_back();
    int ax, ay;
    do_load(150, 70);
    for (int k = 0; k < 8; k++) begin
      ax = int'($urandom_range(255)) - 128;
      ay = int'($urandom_range(255)) - 128;
      run_ticks(3, ax, ay);
    end
    n_cmp++; if ({o_bl_x, o_bl_y} !== {10'(mx / 256), 10'(my / 256)})
      begin n_bad++; $display("FAIL b2b_pos: got (%0d,%0d) required (%0d,%0d)", o_bl_x, o_bl_y, mx / 256, my / 256); end
    n_cmp++; if (exp_q.size() != 0) begin n_bad++; $display("FAIL b2b_drain: got %0d pending required 0", exp_q.size()); end
  endtask

  initial begin
    fork
      scoreboard();
    join_none
    test_reset();
    test_integrate();
    test_saturation();
    test_right_wall();
    test_corner();
    test_load_clamp_bottom();
    test_load_during_pos();
    test_play_toggle();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
